aes_sbox_arbiter: RTL and testbench
===================================

# aes_sbox_arbiter

- Shares a single `aes_sbox_word` (four parallel S-box byte lookups) among `NREQ` requesters.
- Typical requesters: the key-expansion engine (SubWord) and the round datapath (SubBytes, one column per transfer).
- Round-robin arbitration, valid/ready handshake on every port, one registered output stage.
- Sits between the AES round controller / key scheduler and the S-box datapath.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_word`  in  NREQ*32  request words; requester i uses bits [32i+31:32i].
- `req_ready`  out  NREQ  per-requester accept.
- `rsp_valid`  out  1  result valid.
- `rsp_word`  out  32  S-box substituted word; byte-wise, bytes in the same order as `req_word`.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_word`.
- `rsp_ready`  in  1  consumer accepts the result.
- `req_lock`  in  NREQ  present only with `AES_SBOX_ARB_LOCK_EN`; hold the grant.

## Operation
- Transfer on port i: `req_valid[i] & req_ready[i]` at a rising edge.
- `can_accept = ~rsp_valid | rsp_ready`.
- Grant selection:
  - The grant goes to the first valid requester at or after the priority pointer `ptr`, searching upward with wrap-around from NREQ-1 to 0.
  - Exactly one-hot or zero.
- `req_ready[i] = grant[i] & can_accept`. At most one `req_ready` bit is high in any cycle.
- On a transfer from requester g:
  - `rsp_word` <= sbox_word(req_word[g]).
  - `rsp_id` <= g.
  - `rsp_valid` <= 1.
  - `ptr` <= (g+1) mod NREQ.
- On `rsp_valid & rsp_ready` with no new transfer: `rsp_valid` <= 0. `rsp_word` and `rsp_id` hold their last values.
- Accept and drain in the same cycle: the new result replaces the old one, `rsp_valid` stays 1, and there is no bubble.
- No valid requests: `ptr` holds and outputs hold.
- State machine, from the output register's point of view:
  - EMPTY (`rsp_valid`=0) -> FULL on a transfer.
  - FULL -> EMPTY on `rsp_ready` with no transfer.
  - FULL -> FULL on a drain plus a new transfer, or on stall (`rsp_ready`=0, all `req_ready`=0).
- Requesters must not drop `req_valid` or change `req_word` before their transfer completes. The bench checks this with an assertion.
- `req_valid` must not depend combinationally on `req_ready`.

## Timing
- Reset values: `rsp_valid`=0, `rsp_word`=32'h0, `rsp_id`=0, `ptr`=0 (requester 0 has first priority), lock state cleared.
- Latency: a request accepted at edge N gives `rsp_valid`=1 with its data after edge N.
- Throughput: one word per cycle while `rsp_ready`=1.
- `req_ready` is combinational from `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`. There is no combinational path from `req_word` to any output.
- Reset asserted mid-operation: the pending result is discarded, and all outputs return to their reset values asynchronously.
- `NREQ` not a power of two: `ptr` wraps at NREQ-1, never beyond it.

## Configuration
- `AES_SBOX_ARB_LOCK_EN` defined:
  - The `req_lock` port exists.
  - If the requester owning the last transfer still asserts `req_lock[g]`, the grant stays with g:
    - `ptr` is not advanced.
    - Other requesters see `req_ready`=0 even if g is momentarily not valid.
    - This keeps the four SubBytes columns of one state contiguous.
  - The lock releases on the first transfer with `req_lock[g]`=0, or when `req_lock[g]` deasserts; the pointer then advances as normal.
- Not defined: there is no `req_lock` port, and arbitration is pure round-robin on every transfer.

## Structure
- Shared package `aes_pkg`:
  - `AES_WORD_W = 32`.
  - `typedef logic [31:0] aes_word_t`.
  - `AES_SBOX_ARB_MAX_REQ = 8`.
- Sub-module `aes_rr_arb`:
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `grant` and encoded `grant_id`.
  - Combinational; reusable by the key scheduler's bus arbiter.
- One `aes_sbox_word` instance drives the output register through a mux selected by `grant_id`.

## Test plan
- Reset, then requester 0 sends 32'h00000000 with `rsp_ready`=1 -> one cycle later `rsp_valid`=1, `rsp_word`=32'h63636363, `rsp_id`=0.
- Requester 1 sends 32'h01020353 -> `rsp_word`=32'h7C777BED, `rsp_id`=1.
- Both requesters valid continuously with `rsp_ready`=1 -> grants alternate 0,1,0,1 with one result per cycle and no bubbles.
- `rsp_ready`=0 for 3 cycles with a result pending -> all `req_ready`=0 and `rsp_word` stable; after `rsp_ready` rises, the next result follows with no loss or duplication.
- Reset asserted while `rsp_valid`=1 (word 32'hFFFFFFFF -> 32'h16161616) -> `rsp_valid` drops immediately; after release, requester 0 wins first.
- With `AES_SBOX_ARB_LOCK_EN` defined: requester 1 locks for 4 words while requester 0 is valid -> 4 consecutive `rsp_id`=1 results, then requester 0 is granted.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: word type, arbiter limits, output-stage states and
// the forward S-box ROM used by the word-wide substitution datapath.
package aes_pkg;

  localparam int AES_WORD_W           = 32;
  localparam int AES_SBOX_ARB_MAX_REQ = 8;

  typedef logic [AES_WORD_W-1:0] aes_word_t;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  // Byte 0x00 sits in the most significant byte, byte 0xFF in the least.
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return SBOX_ROM[{~b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox_arbiter_if.sv
// Request/response bundle between S-box requesters and aes_sbox_arbiter.
// req_lock exists only when AES_SBOX_ARB_LOCK_EN is defined.
interface aes_sbox_arbiter_if
  import aes_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ*AES_WORD_W-1:0] req_word;
  logic [NREQ-1:0]            req_ready;
  logic                       rsp_valid;
  aes_word_t                  rsp_word;
  logic [IDW-1:0]             rsp_id;
  logic                       rsp_ready;
`ifdef AES_SBOX_ARB_LOCK_EN
  logic [NREQ-1:0]            req_lock;

  modport master (
    output req_valid, req_word, req_lock, rsp_ready,
    input  req_ready, rsp_valid, rsp_word, rsp_id
  );

  modport slave (
    input  req_valid, req_word, req_lock, rsp_ready,
    output req_ready, rsp_valid, rsp_word, rsp_id
  );
`else
  modport master (
    output req_valid, req_word, rsp_ready,
    input  req_ready, rsp_valid, rsp_word, rsp_id
  );

  modport slave (
    input  req_valid, req_word, rsp_ready,
    output req_ready, rsp_valid, rsp_word, rsp_id
  );
`endif

endinterface

// File: rtl/aes_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from NREQ-1 to 0. Grant is one-hot or all zero.
module aes_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    sum      = '0;
    idx      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      idx = sum[IDW-1:0];
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/aes_sbox_word.sv
// Four parallel forward S-box lookups, one per byte of a 32-bit word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  aes_word_t in_word,
  output aes_word_t out_word
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign out_word[8*gi +: 8] = sbox_byte(in_word[8*gi +: 8]);
  end

endmodule

// File: rtl/aes_sbox_arbiter.sv
// Round-robin sharing of one aes_sbox_word among NREQ requesters with a
// single registered result stage. Define AES_SBOX_ARB_LOCK_EN for grant locking.
module aes_sbox_arbiter
  import aes_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic               clk,
  input logic               reset,
  aes_sbox_arbiter_if.slave bus
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  if (NREQ < 2 || NREQ > AES_SBOX_ARB_MAX_REQ) begin : g_nreq_check
    $error("aes_sbox_arbiter: NREQ must be within 2..8");
  end

  arb_state_e     state_reg, state_next;
  aes_word_t      rsp_word_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic [IDW-1:0] ptr_reg, ptr_next;

  logic [NREQ-1:0] arb_req;
  logic [IDW-1:0]  arb_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            can_accept;
  logic            xfer;

  aes_word_t req_words [NREQ];
  aes_word_t sbox_in;
  aes_word_t sbox_out;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
    assign req_words[gi] = bus.req_word[AES_WORD_W*gi +: AES_WORD_W];
  end

`ifdef AES_SBOX_ARB_LOCK_EN
  logic           lock_reg, lock_next;
  logic [IDW-1:0] lock_id_reg, lock_id_next;
  logic           lock_hold;

  // While held, only the lock owner may be granted, valid or not.
  assign lock_hold = lock_reg & bus.req_lock[lock_id_reg];

  always_comb begin
    arb_req = bus.req_valid;
    arb_ptr = ptr_reg;
    if (lock_hold) begin
      arb_req              = '0;
      arb_req[lock_id_reg] = bus.req_valid[lock_id_reg];
      arb_ptr              = lock_id_reg;
    end
  end

  always_comb begin
    ptr_next     = ptr_reg;
    lock_next    = lock_hold;
    lock_id_next = lock_id_reg;
    if (xfer) begin
      lock_next    = bus.req_lock[grant_id];
      lock_id_next = grant_id;
      if (!bus.req_lock[grant_id]) begin
        ptr_next = next_id(grant_id);
      end
    end else if (lock_reg && !lock_hold) begin
      ptr_next = next_id(lock_id_reg);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_reg    <= 1'b0;
      lock_id_reg <= '0;
    end else begin
      lock_reg    <= lock_next;
      lock_id_reg <= lock_id_next;
    end
  end
`else
  assign arb_req = bus.req_valid;
  assign arb_ptr = ptr_reg;

  always_comb begin
    ptr_next = ptr_reg;
    if (xfer) begin
      ptr_next = next_id(grant_id);
    end
  end
`endif

  aes_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req      (arb_req),
    .ptr      (arb_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sbox_in = req_words[grant_id];

  aes_sbox_word u_sbox (
    .in_word  (sbox_in),
    .out_word (sbox_out)
  );

  // A draining consumer frees the stage in the same cycle, so no bubble.
  assign can_accept    = (state_reg == ARB_EMPTY) | bus.rsp_ready;
  assign bus.req_ready = grant & {NREQ{can_accept}};
  assign xfer          = |bus.req_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_EMPTY: if (xfer) state_next = ARB_FULL;
      ARB_FULL:  if (bus.rsp_ready && !xfer) state_next = ARB_EMPTY;
      default:   state_next = ARB_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ARB_EMPTY;
      rsp_word_reg <= '0;
      rsp_id_reg   <= '0;
      ptr_reg      <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (xfer) begin
        rsp_word_reg <= sbox_out;
        rsp_id_reg   <= grant_id;
      end
    end
  end

  assign bus.rsp_valid = (state_reg == ARB_FULL);
  assign bus.rsp_word  = rsp_word_reg;
  assign bus.rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Directed bench for aes_sbox_arbiter: scoreboard of expected results built from
// an arithmetic (GF(2^8) inverse + affine) S-box model and a round-robin model.
module tb_aes_sbox_arbiter;
  import aes_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_sbox_arbiter_if #(.NREQ(N)) bus ();

  aes_sbox_arbiter #(.NREQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int remain [N];

  int          sb_id[$];
  logic [31:0] sb_word[$];
  int          id_log[$];

  int              m_ptr = 0;
  logic            m_locked = 1'b0;
  int              m_lock_id = 0;
  logic [N-1:0]    prev_valid = '0;
  logic [N-1:0]    prev_ready = '0;
  logic [N*32-1:0] prev_word = '0;
  logic            prev_chk = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = ref_sbox(w[8*b +: 8]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int n, input logic [15:0] pat);
    logic [15:0] obs;
    obs = '0;
    chk({tag, "_len"}, id_log.size(), n);
    for (int k = 0; k < id_log.size() && k < 16; k++) obs[k] = (id_log[k] != 0);
    chk(tag, 32'(obs), 32'(pat));
  endtask

  // Model of arbitration and the result register, evaluated mid-cycle.
  always @(negedge clk) begin
    logic [N-1:0] m_ready;
    logic         can;
    logic         lk;
    int           g;
    int           idx;
    if (reset) begin
      sb_id.delete();
      sb_word.delete();
      m_ptr     = 0;
      m_locked  = 1'b0;
      m_lock_id = 0;
      prev_chk  = 1'b0;
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("reset_rsp_word", bus.rsp_word, 32'h0);
      chk("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
    end else begin
      if (prev_chk) begin
        for (int i = 0; i < N; i++) begin
          if (prev_valid[i] && !prev_ready[i]) begin
            chk("hold_valid", 32'(bus.req_valid[i]), 32'h1);
            chk("hold_word", bus.req_word[32*i +: 32], prev_word[32*i +: 32]);
          end
        end
      end
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(sb_word.size() > 0));
      if (sb_word.size() > 0) begin
        chk("rsp_word", bus.rsp_word, sb_word[0]);
        chk("rsp_id", 32'(bus.rsp_id), sb_id[0]);
      end
      lk = 1'b0;
`ifdef AES_SBOX_ARB_LOCK_EN
      lk = m_locked && bus.req_lock[m_lock_id];
`endif
      can = (sb_word.size() == 0) || bus.rsp_ready;
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && bus.req_valid[idx] && !(lk && idx != m_lock_id)) g = idx;
      end
      m_ready = '0;
      if (g >= 0 && can) m_ready[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(m_ready));
      if (sb_word.size() > 0 && bus.rsp_ready) begin
        $display("rsp id=%0d word=%h", sb_id[0], sb_word[0]);
        id_log.push_back(sb_id[0]);
        void'(sb_id.pop_front());
        void'(sb_word.pop_front());
      end
      if (m_ready != '0) begin
        sb_id.push_back(g);
        sb_word.push_back(ref_word(bus.req_word[32*g +: 32]));
`ifdef AES_SBOX_ARB_LOCK_EN
        if (bus.req_lock[g]) begin
          m_locked  = 1'b1;
          m_lock_id = g;
        end else begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % N;
        end
`else
        m_ptr = (g + 1) % N;
`endif
      end else if (m_locked && !lk) begin
        m_locked = 1'b0;
        m_ptr    = (m_lock_id + 1) % N;
      end
      prev_valid = bus.req_valid;
      prev_ready = bus.req_ready;
      prev_word  = bus.req_word;
      prev_chk   = 1'b1;
    end
  end

  task automatic drive(input int i, input logic [31:0] w, input int more);
    bus.req_valid[i]         = 1'b1;
    bus.req_word[32*i +: 32] = w;
    remain[i]                = more;
  endtask

  // One clock: note accepted requests, then present next word or drop valid.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (remain[i] > 0) begin
          remain[i]--;
          bus.req_word[32*i +: 32] = $urandom;
`ifdef AES_SBOX_ARB_LOCK_EN
          bus.req_lock[i] = bus.req_lock[i] && (remain[i] > 0);
`endif
        end else begin
          bus.req_valid[i] = 1'b0;
`ifdef AES_SBOX_ARB_LOCK_EN
          bus.req_lock[i] = 1'b0;
`endif
        end
      end
    end
  endtask

  task automatic idle(output int n, input int budget);
    n = 0;
    while ((bus.req_valid != '0 || bus.rsp_valid) && n < budget) begin
      step();
      n++;
    end
    chk("idle_within_budget", 32'(n < budget), 32'h1);
  endtask

  initial begin
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_word  = '0;
    bus.rsp_ready = 1'b0;
`ifdef AES_SBOX_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
    for (int i = 0; i < N; i++) remain[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_req_ready", 32'(bus.req_ready), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single words: zero word from requester 0, then requester 1.
    bus.rsp_ready = 1'b1;
    drive(0, 32'h00000000, 0);
    step();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_word", bus.rsp_word, 32'h63636363);
    chk("t1_rsp_id", 32'(bus.rsp_id), 32'h0);
    drive(1, 32'h01020353, 0);
    step();
    chk("t2_rsp_word", bus.rsp_word, 32'h7C777BED);
    chk("t2_rsp_id", 32'(bus.rsp_id), 32'h1);
    idle(n, 10);

    // Both requesters streaming: strict alternation, no bubbles.
    id_log.delete();
    drive(0, $urandom, 3);
    drive(1, $urandom, 3);
    idle(n, 30);
    chk("alt_cycles", n, 9);
    check_log("alt_ids", 8, 16'h00AA);

    // Consumer stall with a pending result and a waiting requester.
    id_log.delete();
    bus.rsp_ready = 1'b0;
    w0 = $urandom;
    w1 = $urandom;
    drive(0, w0, 0);
    drive(1, w1, 0);
    step();
    repeat (3) begin
      step();
      chk("stall_req_ready", 32'(bus.req_ready), 32'h0);
      chk("stall_rsp_word", bus.rsp_word, ref_word(w0));
    end
    bus.rsp_ready = 1'b1;
    idle(n, 10);
    chk("stall_cycles", n, 2);
    check_log("stall_ids", 2, 16'h0002);

    // Asynchronous reset with a result pending.
    drive(0, 32'hFFFFFFFF, 0);
    step();
    chk("pre_reset_valid", 32'(bus.rsp_valid), 32'h1);
    chk("pre_reset_word", bus.rsp_word, 32'h16161616);
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 32'(bus.rsp_valid), 32'h0);
    chk("async_reset_word", bus.rsp_word, 32'h0);
    drive(0, $urandom, 0);
    drive(1, $urandom, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    id_log.delete();
    idle(n, 10);
    check_log("reset_ids", 2, 16'h0002);

`ifdef AES_SBOX_ARB_LOCK_EN
    // Requester 1 holds the grant for four words while requester 0 waits.
    drive(0, $urandom, 0);
    idle(n, 10);
    id_log.delete();
    drive(0, $urandom, 0);
    drive(1, $urandom, 3);
    bus.req_lock[1] = 1'b1;
    idle(n, 20);
    check_log("lock_ids", 5, 16'h000F);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
